chip8_timer_bank: RTL

CHIP8_TIMER_BANK -- requirements
Module: chip8_timer_bank

---
 rtl/chip8_timer_bank.sv | 77 +++++++
 1 files changed

// File: rtl/chip8_timer_bank.sv
// chip8_timer_bank: bank of down-count timers decremented by a shared prescaler tick,
// with per-channel auto-reload, expiry pulses and a sound output.
module chip8_timer_bank #(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 16667,
    parameter int SOUND_CH = 1,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              pause_in,
    input  logic              wr_en_in,
    input  logic [CW-1:0]     wr_ch_in,
    input  logic [WIDTH-1:0]  wr_data_in,
    input  logic [NUM_CH-1:0] reload_en_in,
    input  logic [CW-1:0]     rd_ch_in,
    output logic [WIDTH-1:0]  rd_data_out,
    output logic [NUM_CH-1:0] active_out,
    output logic [NUM_CH-1:0] expired_out,
    output logic              tick_out,
    output logic              sound_out
);
    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]                  pre_q, pre_d;
    logic [NUM_CH-1:0][WIDTH-1:0]   cnt_q, cnt_d, rld_q, rld_d;
    logic [NUM_CH-1:0]              exp_q, exp_d;
    logic                           tick_q, tick_d;

    always_comb begin
        tick_d = !pause_in && (pre_q == PW'(TICK_DIV - 1));
        pre_d  = pause_in ? pre_q : (tick_d ? '0 : pre_q + 1'b1);
        cnt_d  = cnt_q;
        rld_d  = rld_q;
        exp_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // a write wins over a same-edge tick, so writing 0 never pulses expiry
            if (wr_en_in && wr_ch_in == CW'(i)) begin
                cnt_d[i] = wr_data_in;
                rld_d[i] = wr_data_in;
            end else if (tick_d && cnt_q[i] != '0) begin
                exp_d[i] = cnt_q[i] == WIDTH'(1);
                cnt_d[i] = (exp_d[i] && reload_en_in[i] && rld_q[i] != '0) ? rld_q[i] : cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            rld_q  <= '0;
            exp_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            rld_q  <= rld_d;
            exp_q  <= exp_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        rd_data_out = '0;
        active_out  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active_out[i] = cnt_q[i] != '0;
            if (rd_ch_in == CW'(i)) rd_data_out = cnt_q[i];
        end
    end

    assign expired_out = exp_q;
    assign tick_out    = tick_q;
    assign sound_out   = active_out[SOUND_CH];
endmodule
